huff_freq_scan_ctrl: RTL and testbench
======================================

HUFF_FREQ_SCAN_CTRL -- requirements
Module: huff_freq_scan_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle pulse that begins a scan; honoured only in IDLE.
REQ-005 SHALL have port: last_addr  input  8  highest histogram address to scan (inclusive); sampled on accepted start.
REQ-006 SHALL have port: skip_zero  input  1  drop zero-frequency entries; sampled on accepted start.
REQ-007 SHALL have port: ram_en  output  1  histogram RAM read enable.
REQ-008 SHALL have port: ram_addr  output  8  histogram RAM read address.
REQ-009 SHALL have port: ram_rdata  input  16  RAM read data, valid exactly one cycle after ram_en.
REQ-010 SHALL have port: out_valid  output  1  symbol/frequency pair available.
REQ-011 SHALL have port: out_ready  input  1  downstream (tree builder) accepts pair.
REQ-012 SHALL have port: out_sym  output  8  symbol (RAM address) of the current pair.
REQ-013 SHALL have port: out_freq  output  16  frequency of the current pair.
REQ-014 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port: done  output  1  one-cycle pulse when a scan has fully drained.
REQ-016 SHALL have port: emit_cnt  output  9  pairs transferred in the current/last scan; holds after done.

Function
REQ-017 SHALL implement FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
REQ-018 IDLE: start SHALL clear emit_cnt, set read pointer 0, latch last_addr/skip_zero, go SCAN.
REQ-019 SCAN: ram_en SHALL assert iff (buf_cnt + inflight - pop) < 2; pop = out_valid & out_ready; ram_addr = read pointer.
REQ-020 Each issued read SHALL increment read pointer by 1; issuing address last_addr SHALL move FSM to DRAIN.
REQ-021 Returning data SHALL tag with its issuing address (registered) and write into a 2-entry FIFO, unless skip_zero=1 and data==0.
REQ-022 Read pointer SHALL never wrap: last_addr=255 issues 0..255 exactly once (256 reads).
REQ-023 out_valid/out_sym/out_freq SHALL come from FIFO head; pair SHALL stay stable while out_valid & !out_ready.
REQ-024 emit_cnt SHALL increment on every pop (max 256).
REQ-025 DRAIN SHALL wait for inflight=0 and FIFO empty, then enter DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-026 With out_ready held high, throughput SHALL be one pair per cycle; first out_valid two cycles after accepted start.
REQ-027 start while busy SHALL be ignored; FIFO SHALL never overflow or drop data under any out_ready pattern.
REQ-028 Simultaneous FIFO push and pop SHALL keep occupancy unchanged and preserve order.

Reset
REQ-029 rst SHALL force IDLE, ram_en=0, ram_addr=0, out_valid=0, out_sym=0, out_freq=0, busy=0, done=0, emit_cnt=0, FIFO empty, inflight=0.
REQ-030 rst mid-scan SHALL abandon the scan; RAM data returning in the cycle after reset SHALL be discarded.
REQ-031 rst SHALL take priority over start in the same cycle.

Structure
REQ-032 Shared package huff_pkg SHALL hold SYM_W=8, FREQ_W=16, the scan-FSM state enum and the {sym,freq} pair struct.
REQ-033 The 2-entry FIFO SHALL be sub-module huff_pair_fifo (push/pop/full/empty/count); the rest stays in this module.

Verification
REQ-034 Histogram freq[i]=i+1, last_addr=3, skip_zero=0, out_ready=1 -> pairs (0,1),(1,2),(2,3),(3,4) on consecutive cycles; done once; emit_cnt=4.
REQ-035 freq = {5,0,0,7}, last_addr=3, skip_zero=1 -> pairs (0,5),(3,7) only; emit_cnt=2; done pulses.
REQ-036 Same as 034 with out_ready toggling 1,0,0,1... -> same four pairs in order, stable while stalled, ram_en never exceeds FIFO credit.
REQ-037 last_addr=255, all freq=1 -> ram_addr 0..255 each once, no wrap, emit_cnt=256.
REQ-038 rst asserted two cycles into a scan -> next cycle all outputs at reset values; fresh start yields a clean scan from address 0.
REQ-039 start pulsed during SCAN -> ignored; scan completes with single done pulse.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared types for the histogram scan path: widths, scan FSM states, symbol/frequency pair.
// Pure declarations, no logic, no latency.
package huff_pkg;
  localparam int SYM_W      = 8;
  localparam int FREQ_W     = 16;
  localparam int CNT_W      = SYM_W + 1;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_e;

  typedef struct packed {
    logic [SYM_W-1:0]  sym;
    logic [FREQ_W-1:0] freq;
  } pair_t;
endpackage

// File: rtl/huff_freq_scan_ctrl_if.sv
// Control, histogram-RAM and pair-output signals of the scan controller.
// master = environment side (drives start/config/RAM data/ready), slave = controller side.
interface huff_freq_scan_ctrl_if;
  import huff_pkg::*;

  logic              start;
  logic [SYM_W-1:0]  last_addr;
  logic              skip_zero;
  logic              ram_en;
  logic [SYM_W-1:0]  ram_addr;
  logic [FREQ_W-1:0] ram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [SYM_W-1:0]  out_sym;
  logic [FREQ_W-1:0] out_freq;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  emit_cnt;

  modport master (
    output start, last_addr, skip_zero, ram_rdata, out_ready,
    input  ram_en, ram_addr, out_valid, out_sym, out_freq, busy, done, emit_cnt
  );

  modport slave (
    input  start, last_addr, skip_zero, ram_rdata, out_ready,
    output ram_en, ram_addr, out_valid, out_sym, out_freq, busy, done, emit_cnt
  );
endinterface

// File: rtl/huff_pair_fifo.sv
// Two-entry pair FIFO; head is registered, data visible the cycle after push.
// Push while full is only taken if a pop frees a slot in the same cycle; pop on empty is ignored.
module huff_pair_fifo
  import huff_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  pair_t      push_dat_i,
  input  logic       pop_i,
  output pair_t      head_dat_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);
  pair_t      mem_q [FIFO_DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign full_o     = (cnt_q == 2'd2);
  assign empty_o    = (cnt_q == 2'd0);
  assign count_o    = cnt_q;
endmodule

// File: rtl/huff_freq_scan_ctrl.sv
// Scans histogram RAM 0..last_addr and streams {sym,freq} pairs; first pair two cycles after start.
// Reads are issued only while FIFO slots plus in-flight reads leave room, so out_ready stalls never drop data.
module huff_freq_scan_ctrl
  import huff_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  huff_freq_scan_ctrl_if.slave  bus
);
  scan_state_e      state_q, state_d;
  logic [SYM_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SYM_W-1:0] last_q, last_d;
  logic             skip_q, skip_d;
  logic [CNT_W-1:0] emit_cnt_q, emit_cnt_d;
  logic [SYM_W-1:0] tag_q;
  logic             inflight_q;

  logic             fifo_full, fifo_empty;
  logic [1:0]       fifo_cnt;
  pair_t            fifo_head, ret_pair;
  logic             pop, push, issue;
  logic [2:0]       occ;

  assign pop = !fifo_empty && bus.out_ready;
  assign occ = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  // A full FIFO implies nothing is in flight, so only a same-cycle pop opens a slot.
  assign issue = (state_q == ST_SCAN) && (fifo_full ? pop : (occ < 3'd2));

  assign push          = inflight_q && !(skip_q && (bus.ram_rdata == '0));
  assign ret_pair.sym  = tag_q;
  assign ret_pair.freq = bus.ram_rdata;

  huff_pair_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (ret_pair),
    .pop_i      (pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    last_d     = last_q;
    skip_d     = skip_q;
    emit_cnt_d = emit_cnt_q + {{(CNT_W-1){1'b0}}, pop};
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_SCAN;
          rd_ptr_d   = '0;
          last_d     = bus.last_addr;
          skip_d     = bus.skip_zero;
          emit_cnt_d = '0;
        end
      end
      ST_SCAN: begin
        // Pointer parks on last_addr instead of wrapping.
        if (issue) begin
          if (rd_ptr_q == last_q) state_d = ST_DRAIN;
          else                    rd_ptr_d = rd_ptr_q + SYM_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      last_q     <= '0;
      skip_q     <= 1'b0;
      emit_cnt_q <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      last_q     <= last_d;
      skip_q     <= skip_d;
      emit_cnt_q <= emit_cnt_d;
      inflight_q <= issue;
      if (issue) tag_q <= rd_ptr_q;
    end
  end

  assign bus.ram_en    = issue;
  assign bus.ram_addr  = rd_ptr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_sym   = fifo_empty ? '0 : fifo_head.sym;
  assign bus.out_freq  = fifo_empty ? '0 : fifo_head.freq;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.emit_cnt  = emit_cnt_q;
endmodule

// File: tb/tb_huff_freq_scan_ctrl.sv
// Bench for huff_freq_scan_ctrl: table of directed scans, reset corner cases and random scans,
// each checked against a pair list computed directly from the histogram contents.
module tb_huff_freq_scan_ctrl;
  import huff_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  huff_freq_scan_ctrl_if bus ();

  huff_freq_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] hist [256];

  // Synchronous-read histogram RAM: data valid the cycle after ram_en.
  always @(posedge clk) begin
    if (bus.ram_en) bus.ram_rdata <= hist[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int last;
    bit skip;
    int hmode;
    int rmode;
    int exp_emit;
    int exp_first;
    bit consec;
    bit mid_start;
  } vec_t;

  vec_t vecs [8];

  task automatic fill_hist(input int hmode);
    for (int i = 0; i < 256; i++) begin
      case (hmode)
        0:       hist[i] = 16'(i + 1);
        2:       hist[i] = 16'd1;
        4:       hist[i] = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        default: hist[i] = 16'd0;
      endcase
    end
    if (hmode == 1) begin
      hist[0] = 16'd5;
      hist[3] = 16'd7;
    end
  endtask

  function automatic bit rdy(input int rmode, input int n);
    case (rmode)
      0:       return 1'b1;
      1:       return ((n - 1) % 3) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_en"},    32'(bus.ram_en), 0);
    chk({tag, "_ram_addr"},  32'(bus.ram_addr), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_sym"},   32'(bus.out_sym), 0);
    chk({tag, "_out_freq"},  32'(bus.out_freq), 0);
    chk({tag, "_busy"},      32'(bus.busy), 0);
    chk({tag, "_done"},      32'(bus.done), 0);
    chk({tag, "_emit_cnt"},  32'(bus.emit_cnt), 0);
  endtask

  // exp_emit < 0: take the count from the reference list; exp_first < 0: no latency check.
  task automatic run_scan(input int last, input bit skip, input int rmode, input int exp_emit,
                          input int exp_first, input bit consec, input bit mid_start);
    pair_t expq [$];
    pair_t p;
    int    want_emit;
    int    first_valid = -1;
    int    first_pop = -1;
    int    last_pop = -1;
    int    npop = 0;
    int    reads = 0;
    int    exp_addr = 0;
    int    held = 0;
    int    dones = 0;
    int    trail = 0;
    bit    drop_next = 1'b0;
    bit    seen_done = 1'b0;
    bit    prev_stall = 1'b0;
    logic [7:0]  prev_sym = '0;
    logic [15:0] prev_freq = '0;

    for (int i = 0; i <= last; i++) begin
      if (!(skip && hist[i] == 16'd0)) begin
        p.sym  = 8'(i);
        p.freq = hist[i];
        expq.push_back(p);
      end
    end
    want_emit = (exp_emit >= 0) ? exp_emit : expq.size();

    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.last_addr = 8'(last);
    bus.skip_zero = skip;

    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk);
      #1;
      bus.start = mid_start && (n == 3);
      if (mid_start) begin
        bus.last_addr = 8'd200;
        bus.skip_zero = ~skip;
      end
      bus.out_ready = rdy(rmode, n);
      @(negedge clk);

      if (drop_next) held--;
      drop_next = 1'b0;
      if (bus.ram_en) begin
        chk("ram_addr_seq", 32'(bus.ram_addr), 32'(exp_addr));
        reads++;
        held++;
        drop_next = skip && (hist[bus.ram_addr] == 16'd0);
        exp_addr++;
      end

      if (prev_stall) begin
        chk("stall_valid_hold", 32'(bus.out_valid), 1);
        chk("stall_sym_hold", 32'(bus.out_sym), 32'(prev_sym));
        chk("stall_freq_hold", 32'(bus.out_freq), 32'(prev_freq));
      end

      if (bus.out_valid && first_valid < 0) first_valid = n - 1;

      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("extra_pair", 32'(npop), 32'(want_emit - 1));
        end else begin
          p = expq.pop_front();
          chk("pair_sym", 32'(bus.out_sym), 32'(p.sym));
          chk("pair_freq", 32'(bus.out_freq), 32'(p.freq));
        end
        held--;
        npop++;
        if (first_pop < 0) first_pop = n;
        last_pop = n;
      end

      if (bus.ram_en) chk("read_credit", 32'(held <= FIFO_DEPTH), 1);

      prev_stall = bus.out_valid && !bus.out_ready;
      prev_sym   = bus.out_sym;
      prev_freq  = bus.out_freq;

      if (bus.done) begin
        dones++;
        if (!seen_done) begin
          seen_done = 1'b1;
          chk("emit_cnt_at_done", 32'(bus.emit_cnt), 32'(want_emit));
          chk("pairs_left_at_done", 32'(expq.size()), 0);
          chk("reads_total", 32'(reads), 32'(last + 1));
        end
      end else if (seen_done) begin
        trail++;
        chk("idle_after_done", 32'(bus.busy), 0);
        if (trail >= 3) break;
      end
    end

    bus.start = 1'b0;
    chk("done_seen", 32'(seen_done), 1);
    chk("done_pulses", 32'(dones), 1);
    chk("emit_cnt_hold", 32'(bus.emit_cnt), 32'(want_emit));
    if (exp_first >= 0) chk("first_valid_latency", 32'(first_valid), 32'(exp_first));
    if (consec) chk("back_to_back", 32'(last_pop - first_pop + 1), 32'(npop));
  endtask

  initial begin
    vecs[0] = '{last: 3,   skip: 0, hmode: 0, rmode: 0, exp_emit: 4,   exp_first: 2,  consec: 1, mid_start: 0};
    vecs[1] = '{last: 3,   skip: 1, hmode: 1, rmode: 0, exp_emit: 2,   exp_first: 2,  consec: 0, mid_start: 0};
    vecs[2] = '{last: 3,   skip: 0, hmode: 0, rmode: 1, exp_emit: 4,   exp_first: 2,  consec: 0, mid_start: 0};
    vecs[3] = '{last: 255, skip: 0, hmode: 2, rmode: 0, exp_emit: 256, exp_first: 2,  consec: 1, mid_start: 0};
    vecs[4] = '{last: 3,   skip: 0, hmode: 0, rmode: 0, exp_emit: 4,   exp_first: 2,  consec: 1, mid_start: 1};
    vecs[5] = '{last: 0,   skip: 0, hmode: 0, rmode: 0, exp_emit: 1,   exp_first: 2,  consec: 1, mid_start: 0};
    vecs[6] = '{last: 7,   skip: 1, hmode: 3, rmode: 0, exp_emit: 0,   exp_first: -1, consec: 0, mid_start: 0};
    vecs[7] = '{last: 9,   skip: 0, hmode: 1, rmode: 1, exp_emit: 10,  exp_first: 2,  consec: 0, mid_start: 0};

    bus.start     = 1'b0;
    bus.last_addr = '0;
    bus.skip_zero = 1'b0;
    bus.out_ready = 1'b0;
    bus.ram_rdata = '0;
    fill_hist(3);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Reset wins over a simultaneous start.
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.last_addr = 8'd3;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_over_start_busy", 32'(bus.busy), 0);
    chk("rst_over_start_ram_en", 32'(bus.ram_en), 0);

    for (int v = 0; v < 8; v++) begin
      fill_hist(vecs[v].hmode);
      run_scan(vecs[v].last, vecs[v].skip, vecs[v].rmode, vecs[v].exp_emit,
               vecs[v].exp_first, vecs[v].consec, vecs[v].mid_start);
    end

    // Reset two cycles into a scan, then a clean rescan.
    fill_hist(0);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.last_addr = 8'd20;
    bus.skip_zero = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midscan_rst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(bus.out_valid), 0);
      chk("post_rst_emit_cnt", 32'(bus.emit_cnt), 0);
    end
    run_scan(3, 1'b0, 0, 4, 2, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_hist(4);
      run_scan(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 2, -1, -1, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
